// File: rtl/i2c_fifo_ctrl.sv
// rtl/i2c_fifo_ctrl.sv - TX/RX FIFO stage between the I2C register block and byte engine

// Single-clock FWFT FIFO with a separate count register and soft clear
module i2c_fifo_ctrl_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int OCYW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            srstn,
  input  logic            wr,
  input  logic [W-1:0]    wdat,
  input  logic            rd,
  output logic [W-1:0]    rdat,
  output logic [OCYW-1:0] count,
  output logic [OCYW-1:0] count_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCYW-1:0] FULL = OCYW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Acceptance looks only at the registered count, so a full FIFO never
  // pushes through and an empty FIFO never bypasses.
  assign push_ok = srstn && wr && (count < FULL);
  assign pop_ok  = srstn && rd && (count != '0);

  // Next occupancy; soft reset wins over any traffic in the same cycle
  always_comb begin
    count_nxt = count;
    if (!srstn) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count + OCYW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - OCYW'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (!srstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage array; contents are left alone by reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdat;
  end

  // Head entry stays visible through the pop cycle; zero when empty
  assign rdat = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// Top: TX and RX FIFOs plus registered interrupt requests
module i2c_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int TXW   = 10,
  parameter int RXW   = 8,
  parameter int OCYW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            srstn,
  input  logic            tx_fifo_wr,
  input  logic [TXW-1:0]  tx_fifo_wdat,
  output logic [OCYW-1:0] tx_fifo_ocy,
  input  logic            tx_rd,
  output logic [TXW-1:0]  tx_rdat,
  output logic            tx_empty,
  input  logic            rx_wr,
  input  logic [RXW-1:0]  rx_wdat,
  output logic            rx_full,
  input  logic            rx_fifo_rd,
  output logic [RXW-1:0]  rx_fifo_rdat,
  output logic [OCYW-1:0] rx_fifo_ocy,
  input  logic [4:0]      rx_fifo_pirq,
  output logic [5:0]      fifo_irq
);

  localparam logic [OCYW-1:0] FULL = OCYW'(DEPTH);
  localparam logic [OCYW-1:0] HALF = OCYW'(DEPTH / 2);
  localparam logic [5:0]      THR_MAX = 6'(DEPTH);

  logic [OCYW-1:0] tx_cnt_nxt;
  logic [OCYW-1:0] rx_cnt_nxt;
  logic [5:0]      thr_sum;
  logic [5:0]      thr;
  logic            tx_ovf_ev;
  logic            rx_ovf_ev;
  logic            rx_udf_ev;
  logic [5:0]      irq_nxt;

  i2c_fifo_ctrl_buf #(.DEPTH(DEPTH), .W(TXW), .OCYW(OCYW)) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .srstn     (srstn),
    .wr        (tx_fifo_wr),
    .wdat      (tx_fifo_wdat),
    .rd        (tx_rd),
    .rdat      (tx_rdat),
    .count     (tx_fifo_ocy),
    .count_nxt (tx_cnt_nxt)
  );

  i2c_fifo_ctrl_buf #(.DEPTH(DEPTH), .W(RXW), .OCYW(OCYW)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .srstn     (srstn),
    .wr        (rx_wr),
    .wdat      (rx_wdat),
    .rd        (rx_fifo_rd),
    .rdat      (rx_fifo_rdat),
    .count     (rx_fifo_ocy),
    .count_nxt (rx_cnt_nxt)
  );

  assign tx_empty = (tx_fifo_ocy == '0);
  assign rx_full  = (rx_fifo_ocy == FULL);

  // Threshold is pirq+1 in 6 bits so pirq=31 gives 32, then clamped to DEPTH
  always_comb begin
    thr_sum = {1'b0, rx_fifo_pirq} + 6'd1;
    thr     = (thr_sum > THR_MAX) ? THR_MAX : thr_sum;
  end

  // Dropped-request events; suppressed while soft reset is held
  assign tx_ovf_ev = srstn && tx_fifo_wr && (tx_fifo_ocy == FULL);
  assign rx_ovf_ev = srstn && rx_wr      && (rx_fifo_ocy == FULL);
  assign rx_udf_ev = srstn && rx_fifo_rd && (rx_fifo_ocy == '0);

  // Level bits follow the count being loaded this edge so they move with ocy
  always_comb begin
    irq_nxt    = '0;
    irq_nxt[0] = (tx_cnt_nxt == '0);
    irq_nxt[1] = (tx_cnt_nxt <= HALF);
    irq_nxt[2] = (6'(rx_cnt_nxt) >= thr);
    irq_nxt[3] = tx_ovf_ev;
    irq_nxt[4] = rx_ovf_ev;
    irq_nxt[5] = rx_udf_ev;
  end

  // Interrupt request register, cleared by either reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_irq <= '0;
    end else if (!srstn) begin
      fifo_irq <= '0;
    end else begin
      fifo_irq <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_fifo_ctrl.sv
// tb/tb_i2c_fifo_ctrl.sv - directed self-checking bench for i2c_fifo_ctrl
`timescale 1ns/1ps
module tb_i2c_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       srstn;
  logic       tx_fifo_wr;
  logic [9:0] tx_fifo_wdat;
  logic [4:0] tx_fifo_ocy;
  logic       tx_rd;
  logic [9:0] tx_rdat;
  logic       tx_empty;
  logic       rx_wr;
  logic [7:0] rx_wdat;
  logic       rx_full;
  logic       rx_fifo_rd;
  logic [7:0] rx_fifo_rdat;
  logic [4:0] rx_fifo_ocy;
  logic [4:0] rx_fifo_pirq;
  logic [5:0] fifo_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_fifo_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .srstn        (srstn),
    .tx_fifo_wr   (tx_fifo_wr),
    .tx_fifo_wdat (tx_fifo_wdat),
    .tx_fifo_ocy  (tx_fifo_ocy),
    .tx_rd        (tx_rd),
    .tx_rdat      (tx_rdat),
    .tx_empty     (tx_empty),
    .rx_wr        (rx_wr),
    .rx_wdat      (rx_wdat),
    .rx_full      (rx_full),
    .rx_fifo_rd   (rx_fifo_rd),
    .rx_fifo_rdat (rx_fifo_rdat),
    .rx_fifo_ocy  (rx_fifo_ocy),
    .rx_fifo_pirq (rx_fifo_pirq),
    .fifo_irq     (fifo_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_fifo_wr = 1'b0; tx_rd = 1'b0; rx_wr = 1'b0; rx_fifo_rd = 1'b0;
  endtask

  task automatic test_reset();
    tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h123; rx_wr = 1'b1; rx_wdat = 8'h9A;
    tick(); tick();
    idle();
    rstn = 1'b0;
    #2;
    n_cmp++; if (tx_fifo_ocy !== 5'd0) begin n_err++; $display("FAIL rst_tx_ocy got %0d exp 0", tx_fifo_ocy); end
    n_cmp++; if (rx_fifo_ocy !== 5'd0) begin n_err++; $display("FAIL rst_rx_ocy got %0d exp 0", rx_fifo_ocy); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL rst_tx_empty got %b exp 1", tx_empty); end
    n_cmp++; if (rx_full !== 1'b0) begin n_err++; $display("FAIL rst_rx_full got %b exp 0", rx_full); end
    n_cmp++; if (fifo_irq !== 6'b000000) begin n_err++; $display("FAIL rst_irq_low got %b exp 000000", fifo_irq); end
    n_cmp++; if (rx_fifo_rdat !== 8'h00) begin n_err++; $display("FAIL rst_rx_rdat got %h exp 00", rx_fifo_rdat); end
    tick();
    rstn = 1'b1;
    tick();
    n_cmp++; if (fifo_irq !== 6'b000011) begin n_err++; $display("FAIL rst_irq got %b exp 000011", fifo_irq); end
  endtask

  task automatic test_tx_fill();
    for (int i = 0; i < 16; i++) begin
      tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h100 + 10'(i);
      tick();
    end
    n_cmp++; if (tx_fifo_ocy !== 5'd16) begin n_err++; $display("FAIL fill_ocy got %0d exp 16", tx_fifo_ocy); end
    n_cmp++; if (fifo_irq[3] !== 1'b0) begin n_err++; $display("FAIL fill_no_ovf got %b exp 0", fifo_irq[3]); end
    tx_fifo_wdat = 10'h2AA;
    tick();
    tx_fifo_wr = 1'b0;
    n_cmp++; if (fifo_irq !== 6'b001000) begin n_err++; $display("FAIL ovf_pulse got %b exp 001000", fifo_irq); end
    n_cmp++; if (tx_fifo_ocy !== 5'd16) begin n_err++; $display("FAIL ovf_ocy got %0d exp 16", tx_fifo_ocy); end
    tick();
    n_cmp++; if (fifo_irq[3] !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle got %b exp 0", fifo_irq[3]); end
    for (int i = 0; i < 16; i++) begin
      tx_rd = 1'b1;
      n_cmp++; if (tx_rdat !== 10'h100 + 10'(i)) begin n_err++; $display("FAIL tx_pop%0d got %h exp %h", i, tx_rdat, 10'h100 + 10'(i)); end
      tick();
    end
    tx_rd = 1'b0;
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b exp 1", tx_empty); end
    n_cmp++; if (tx_rdat !== 10'h000) begin n_err++; $display("FAIL drain_rdat got %h exp 000", tx_rdat); end
    n_cmp++; if (fifo_irq[1:0] !== 2'b11) begin n_err++; $display("FAIL drain_irq got %b exp 11", fifo_irq[1:0]); end
  endtask

  task automatic test_rx_thr();
    logic [7:0] vals [4];
    logic [7:0] exp_rd [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_rd = '{8'h22, 8'h33, 8'h44, 8'h00};
    rx_fifo_pirq = 5'd3;
    for (int i = 0; i < 4; i++) begin
      rx_wr = 1'b1; rx_wdat = vals[i];
      tick();
      if (i == 2) begin
        n_cmp++; if (fifo_irq[2] !== 1'b0) begin n_err++; $display("FAIL thr_early got %b exp 0", fifo_irq[2]); end
      end
    end
    rx_wr = 1'b0;
    n_cmp++; if (fifo_irq[2] !== 1'b1) begin n_err++; $display("FAIL thr_rise got %b exp 1", fifo_irq[2]); end
    rx_fifo_rd = 1'b1;
    n_cmp++; if (rx_fifo_rdat !== 8'h11) begin n_err++; $display("FAIL rx_pop_cycle got %h exp 11", rx_fifo_rdat); end
    tick();
    rx_fifo_rd = 1'b0;
    n_cmp++; if (rx_fifo_ocy !== 5'd3) begin n_err++; $display("FAIL rx_ocy3 got %0d exp 3", rx_fifo_ocy); end
    n_cmp++; if (fifo_irq[2] !== 1'b0) begin n_err++; $display("FAIL thr_drop got %b exp 0", fifo_irq[2]); end
    for (int i = 0; i < 4; i++) begin
      rx_fifo_rd = 1'b1;
      n_cmp++; if (rx_fifo_rdat !== exp_rd[i]) begin n_err++; $display("FAIL rx_rd%0d got %h exp %h", i, rx_fifo_rdat, exp_rd[i]); end
      n_cmp++; if (fifo_irq[5] !== 1'b0) begin n_err++; $display("FAIL udf_early%0d got %b exp 0", i, fifo_irq[5]); end
      tick();
    end
    rx_fifo_rd = 1'b0;
    n_cmp++; if (fifo_irq[5] !== 1'b1) begin n_err++; $display("FAIL udf_pulse got %b exp 1", fifo_irq[5]); end
    tick();
    n_cmp++; if (fifo_irq[5] !== 1'b0) begin n_err++; $display("FAIL udf_one_cycle got %b exp 0", fifo_irq[5]); end
    rx_fifo_pirq = 5'd0;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'(i);
      tick();
    end
    tx_fifo_wdat = 10'h006; tx_rd = 1'b1;
    n_cmp++; if (tx_rdat !== 10'h001) begin n_err++; $display("FAIL sim5_head got %h exp 001", tx_rdat); end
    tick();
    idle();
    n_cmp++; if (tx_fifo_ocy !== 5'd5) begin n_err++; $display("FAIL sim5_ocy got %0d exp 5", tx_fifo_ocy); end
    for (int i = 2; i <= 6; i++) begin
      tx_rd = 1'b1;
      n_cmp++; if (tx_rdat !== 10'(i)) begin n_err++; $display("FAIL sim5_order%0d got %h exp %h", i, tx_rdat, 10'(i)); end
      tick();
    end
    tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h03C; tx_rd = 1'b1;
    tick();
    idle();
    n_cmp++; if (tx_fifo_ocy !== 5'd1) begin n_err++; $display("FAIL sim0_ocy got %0d exp 1", tx_fifo_ocy); end
    n_cmp++; if (tx_rdat !== 10'h03C) begin n_err++; $display("FAIL sim0_rdat got %h exp 03C", tx_rdat); end
    tx_rd = 1'b1; tick(); idle();
    for (int i = 0; i < 16; i++) begin
      tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h200 + 10'(i);
      tick();
    end
    tx_fifo_wdat = 10'h155; tx_rd = 1'b1;
    tick();
    idle();
    n_cmp++; if (tx_fifo_ocy !== 5'd15) begin n_err++; $display("FAIL sim16_ocy got %0d exp 15", tx_fifo_ocy); end
    n_cmp++; if (fifo_irq[3] !== 1'b1) begin n_err++; $display("FAIL sim16_ovf got %b exp 1", fifo_irq[3]); end
    for (int i = 1; i < 16; i++) begin
      tx_rd = 1'b1;
      n_cmp++; if (tx_rdat !== 10'h200 + 10'(i)) begin n_err++; $display("FAIL sim16_order%0d got %h exp %h", i, tx_rdat, 10'h200 + 10'(i)); end
      tick();
    end
    idle();
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL sim16_empty got %b exp 1", tx_empty); end
  endtask

  task automatic test_wrap();
    logic [9:0] q [$];
    logic [9:0] d;
    logic       w;
    logic       r;
    logic       pu;
    logic       po;
    for (int i = 0; i < 40; i++) begin
      w = ((i % 4) != 3);
      r = ((i % 3) == 0);
      d = 10'((i * 37 + 5) & 10'h3FF);
      tx_fifo_wr = w; tx_fifo_wdat = d; tx_rd = r;
      if (r && q.size() > 0) begin
        n_cmp++; if (tx_rdat !== q[0]) begin n_err++; $display("FAIL wrap_data%0d got %h exp %h", i, tx_rdat, q[0]); end
      end
      pu = w && (q.size() < 16);
      po = r && (q.size() > 0);
      tick();
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
      n_cmp++; if (tx_fifo_ocy !== 5'(q.size())) begin n_err++; $display("FAIL wrap_ocy%0d got %0d exp %0d", i, tx_fifo_ocy, q.size()); end
    end
    idle();
    while (q.size() > 0) begin
      tx_rd = 1'b1;
      n_cmp++; if (tx_rdat !== q[0]) begin n_err++; $display("FAIL wrap_drain got %h exp %h", tx_rdat, q[0]); end
      void'(q.pop_front());
      tick();
    end
    idle();
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b exp 1", tx_empty); end

    rx_fifo_pirq = 5'd31;
    for (int i = 0; i < 15; i++) begin
      rx_wr = 1'b1; rx_wdat = 8'(8'hA0 + i);
      tick();
    end
    n_cmp++; if (fifo_irq[2] !== 1'b0) begin n_err++; $display("FAIL pirq31_15 got %b exp 0", fifo_irq[2]); end
    rx_wdat = 8'hAF;
    tick();
    n_cmp++; if (fifo_irq[2] !== 1'b1) begin n_err++; $display("FAIL pirq31_16 got %b exp 1", fifo_irq[2]); end
    n_cmp++; if (rx_full !== 1'b1) begin n_err++; $display("FAIL rx_full got %b exp 1", rx_full); end
    rx_wdat = 8'hEE;
    tick();
    rx_wr = 1'b0;
    n_cmp++; if (fifo_irq[4] !== 1'b1) begin n_err++; $display("FAIL rx_ovf got %b exp 1", fifo_irq[4]); end
    for (int i = 0; i < 16; i++) begin
      rx_fifo_rd = 1'b1;
      n_cmp++; if (rx_fifo_rdat !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL rx_full_rd%0d got %h exp %h", i, rx_fifo_rdat, 8'(8'hA0 + i)); end
      tick();
    end
    idle();
    n_cmp++; if (rx_fifo_ocy !== 5'd0) begin n_err++; $display("FAIL rx_full_drain got %0d exp 0", rx_fifo_ocy); end
    rx_fifo_pirq = 5'd0;
  endtask

  task automatic test_soft_reset();
    for (int i = 0; i < 9; i++) begin
      tx_fifo_wr = (i < 7); tx_fifo_wdat = 10'h040 + 10'(i);
      rx_wr = 1'b1; rx_wdat = 8'h70 + 8'(i);
      tick();
    end
    idle();
    n_cmp++; if (tx_fifo_ocy !== 5'd7) begin n_err++; $display("FAIL srst_pre_tx got %0d exp 7", tx_fifo_ocy); end
    n_cmp++; if (rx_fifo_ocy !== 5'd9) begin n_err++; $display("FAIL srst_pre_rx got %0d exp 9", rx_fifo_ocy); end
    srstn = 1'b0; tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h3FF; rx_wr = 1'b1; rx_wdat = 8'hFF; rx_fifo_rd = 1'b1;
    tick();
    srstn = 1'b1;
    idle();
    n_cmp++; if (tx_fifo_ocy !== 5'd0) begin n_err++; $display("FAIL srst_tx_ocy got %0d exp 0", tx_fifo_ocy); end
    n_cmp++; if (rx_fifo_ocy !== 5'd0) begin n_err++; $display("FAIL srst_rx_ocy got %0d exp 0", rx_fifo_ocy); end
    n_cmp++; if (fifo_irq !== 6'b000000) begin n_err++; $display("FAIL srst_irq got %b exp 000000", fifo_irq); end
    n_cmp++; if (tx_rdat !== 10'h000) begin n_err++; $display("FAIL srst_tx_rdat got %h exp 000", tx_rdat); end
    tx_fifo_wr = 1'b1; tx_fifo_wdat = 10'h0AB; rx_wr = 1'b1; rx_wdat = 8'h5C;
    tick();
    idle();
    n_cmp++; if (fifo_irq[5:3] !== 3'b000) begin n_err++; $display("FAIL srst_no_ev got %b exp 000", fifo_irq[5:3]); end
    n_cmp++; if (tx_rdat !== 10'h0AB) begin n_err++; $display("FAIL srst_tx_fresh got %h exp 0AB", tx_rdat); end
    n_cmp++; if (rx_fifo_rdat !== 8'h5C) begin n_err++; $display("FAIL srst_rx_fresh got %h exp 5C", rx_fifo_rdat); end
    n_cmp++; if (tx_fifo_ocy !== 5'd1 || rx_fifo_ocy !== 5'd1) begin n_err++; $display("FAIL srst_ocy got %0d/%0d exp 1/1", tx_fifo_ocy, rx_fifo_ocy); end
  endtask

  initial begin
    rstn = 1'b0; srstn = 1'b1; rx_fifo_pirq = 5'd0;
    tx_fifo_wdat = '0; rx_wdat = '0;
    idle();
    tick(); tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_tx_fill();
    test_rx_thr();
    test_back_to_back();
    test_wrap();
    test_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
